// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one sram-like master port between inst and data requesters
module sram_like_arbiter #(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    output logic              busy
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0] MAX_S = SW'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t          state, state_nx;
    logic            own_data;
    logic [SW-1:0]   streak;
    logic            grant;
    logic            pick_inst;

    assign grant      = inst_req || data_req;
    assign pick_inst  = inst_req && (!data_req || streak == MAX_S);
    assign busy       = state != IDLE;
    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;

    // State register; reset abandons any transaction in flight
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and handshake forwarding to the owning requester only
    always_comb begin
        state_nx     = state;
        m_req        = 1'b0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        case (state)
            IDLE: state_nx = grant ? REQ : IDLE;
            REQ: begin
                m_req        = 1'b1;
                inst_addr_ok = !own_data && m_addr_ok;
                data_addr_ok = own_data && m_addr_ok;
                inst_data_ok = !own_data && m_addr_ok && m_data_ok;
                data_data_ok = own_data && m_addr_ok && m_data_ok;
                if (m_addr_ok) state_nx = m_data_ok ? IDLE : WAIT;
            end
            WAIT: begin
                inst_data_ok = !own_data && m_data_ok;
                data_data_ok = own_data && m_data_ok;
                if (m_data_ok) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Latch the winner's request fields and track back-to-back data grants that kept inst waiting
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_wr     <= 1'b0;
            m_size   <= 2'd0;
            m_addr   <= '0;
            m_wdata  <= '0;
            own_data <= 1'b0;
            streak   <= '0;
        end else if (state == IDLE && grant) begin
            m_wr     <= pick_inst ? inst_wr    : data_wr;
            m_size   <= pick_inst ? inst_size  : data_size;
            m_addr   <= pick_inst ? inst_addr  : data_addr;
            m_wdata  <= pick_inst ? inst_wdata : data_wdata;
            own_data <= !pick_inst;
            streak   <= (pick_inst || !inst_req) ? '0 : (streak == MAX_S ? MAX_S : streak + 1'b1);
        end
    end

    // The owner must keep its request up until it has been accepted
    a_req_held: assert property (@(posedge aclk) disable iff (!aresetn)
        (state == REQ) |-> (own_data ? data_req : inst_req));

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: vector table, corner sequences and randomized model check of the arbiter
module tb_sram_like_arbiter;
    localparam int MAXS = 4;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        m_req, m_wr, m_addr_ok, m_data_ok, busy;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          ireq;
        bit          dreq;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ad;
        int          dd;
        bit          exp_data;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[5];
    bit   ord[6];
    bit   ip, dp, wd;
    int   dstreak;

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DATA_STREAK(MAXS)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .busy(busy)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string n);
        chk({n, "_m_req"}, m_req, 0);
        chk({n, "_busy"}, busy, 0);
        chk({n, "_ok"}, {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}, 0);
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
        #1;
        chk_idle_outputs("reset");
        chk("reset_fields", {m_wr, m_size, m_addr, m_wdata} == '0, 1);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic drop(input bit dsel);
        if (dsel) data_req = 0;
        else inst_req = 0;
    endtask

    // Caller drives the requests at a negedge; the grant edge is the next posedge.
    task automatic txn(input bit dsel, input logic wr, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wdat, input int ad, input int dd, input logic [31:0] rd);
        @(posedge aclk);
        for (int i = 0; i <= ad; i++) begin
            @(negedge aclk);
            m_addr_ok = (i == ad);
            m_data_ok = (i == ad) ? (dd == 0) : 1'($urandom_range(0, 1));
            m_rdata = rd;
            #1;
            chk("req_m_req", m_req, 1);
            chk("req_busy", busy, 1);
            chk("req_m_addr", m_addr, a);
            if (i == 0) begin
                chk("req_m_wr", m_wr, wr);
                chk("req_m_size", m_size, sz);
                chk("req_m_wdata", m_wdata, wdat);
            end
            chk("own_addr_ok", dsel ? data_addr_ok : inst_addr_ok, i == ad);
            chk("other_addr_ok", dsel ? inst_addr_ok : data_addr_ok, 0);
            chk("own_data_ok_req", dsel ? data_data_ok : inst_data_ok, (i == ad) && (dd == 0));
            chk("other_data_ok_req", dsel ? inst_data_ok : data_data_ok, 0);
            if (i == ad && dd == 0) chk("rdata_req", dsel ? data_rdata : inst_rdata, rd);
        end
        @(posedge aclk);
        for (int j = 1; j <= dd; j++) begin
            @(negedge aclk);
            drop(dsel);
            m_addr_ok = 0;
            m_data_ok = (j == dd);
            #1;
            chk("wait_m_req", m_req, 0);
            chk("wait_busy", busy, 1);
            chk("wait_m_addr", m_addr, a);
            chk("wait_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
            chk("own_data_ok", dsel ? data_data_ok : inst_data_ok, j == dd);
            chk("other_data_ok", dsel ? inst_data_ok : data_data_ok, 0);
            if (j == dd) chk("rdata", dsel ? data_rdata : inst_rdata, rd);
            @(posedge aclk);
        end
        @(negedge aclk);
        drop(dsel);
        m_addr_ok = 0;
        m_data_ok = 0;
        #1;
        chk_idle_outputs("done");
        chk("done_m_addr_held", m_addr, a);
    endtask

    initial begin
        tbl[0] = '{1, 0, 0, 2'd2, 32'hBFC00000, 32'h0,        32'h0,        32'h3C080001, 0, 2,  0, 32'hBFC00000};
        tbl[1] = '{1, 1, 0, 2'd2, 32'hBFC00040, 32'h80001000, 32'h0,        32'h11223344, 1, 1,  1, 32'h80001000};
        tbl[2] = '{0, 1, 1, 2'd2, 32'h0,        32'h80002004, 32'hDEADBEEF, 32'h0,        0, 0,  1, 32'h80002004};
        tbl[3] = '{0, 1, 0, 2'd0, 32'h0,        32'h80000003, 32'h0,        32'h000000A5, 10, 0, 1, 32'h80000003};
        tbl[4] = '{1, 0, 0, 2'd2, 32'hBFC00100, 32'h0,        32'h0,        32'hCAFEF00D, 2, 3,  0, 32'hBFC00100};
        ord = '{1, 1, 1, 1, 0, 1};

        for (int k = 0; k < 5; k++) begin
            do_reset();
            inst_req = tbl[k].ireq; inst_wr = 0; inst_size = 2'd2;
            inst_addr = tbl[k].iaddr; inst_wdata = 0;
            data_req = tbl[k].dreq; data_wr = tbl[k].wr; data_size = tbl[k].size;
            data_addr = tbl[k].daddr; data_wdata = tbl[k].wdata;
            txn(tbl[k].exp_data, tbl[k].exp_data ? tbl[k].wr : 1'b0,
                tbl[k].exp_data ? tbl[k].size : 2'd2, tbl[k].exp_addr,
                tbl[k].exp_data ? tbl[k].wdata : 32'h0, tbl[k].ad, tbl[k].dd, tbl[k].rdata);
        end

        do_reset();
        inst_req = 1; inst_size = 2'd2; inst_addr = 32'hBFC00000;
        data_req = 1; data_size = 2'd2; data_addr = 32'h80001000;
        txn(1, 0, 2'd2, 32'h80001000, 0, 0, 1, 32'h01010101);
        txn(0, 0, 2'd2, 32'hBFC00000, 0, 0, 1, 32'h02020202);

        do_reset();
        inst_req = 1; inst_size = 2'd2; inst_addr = 32'hBFC00010;
        data_req = 1; data_size = 2'd2; data_addr = 32'h80003000;
        for (int k = 0; k < 6; k++) begin
            txn(ord[k], 0, 2'd2, ord[k] ? 32'h80003000 : 32'hBFC00010, 0, 0, 1, $urandom);
            if (ord[k]) data_req = 1;
            else inst_req = 1;
        end

        do_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge aclk);
            m_addr_ok = 1; m_data_ok = 1;
            #1;
            chk_idle_outputs("stray");
        end
        @(negedge aclk);
        m_addr_ok = 0; m_data_ok = 0;
        data_req = 1; data_addr = 32'h80004000;
        @(posedge aclk);
        @(negedge aclk);
        m_addr_ok = 1;
        @(posedge aclk);
        @(negedge aclk);
        data_req = 0; m_addr_ok = 0;
        #1;
        chk("wait_before_reset_busy", busy, 1);
        aresetn = 0;
        #1;
        chk_idle_outputs("mid_reset");
        chk("mid_reset_m_addr", m_addr, 0);
        @(negedge aclk);
        aresetn = 1;
        m_data_ok = 1;
        #1;
        chk_idle_outputs("late_data_ok");
        @(negedge aclk);
        m_data_ok = 0;
        #1;
        chk_idle_outputs("after_late");

        do_reset();
        ip = 0; dp = 0; dstreak = 0;
        for (int n = 0; n < 80; n++) begin
            if (!ip && ($urandom_range(0, 1) == 1)) begin
                ip = 1; inst_req = 1; inst_wr = 1'($urandom_range(0, 1));
                inst_size = 2'($urandom_range(0, 2)); inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (!dp && ($urandom_range(0, 1) == 1)) begin
                dp = 1; data_req = 1; data_wr = 1'($urandom_range(0, 1));
                data_size = 2'($urandom_range(0, 2)); data_addr = $urandom; data_wdata = $urandom;
            end
            if (!ip && !dp) begin
                dp = 1; data_req = 1; data_wr = 0; data_size = 2'd2;
                data_addr = $urandom; data_wdata = $urandom;
            end
            wd = dp && (!ip || dstreak < MAXS);
            dstreak = (wd && ip) ? dstreak + 1 : 0;
            txn(wd, wd ? data_wr : inst_wr, wd ? data_size : inst_size,
                wd ? data_addr : inst_addr, wd ? data_wdata : inst_wdata,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            if (wd) dp = 0;
            else ip = 0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
